// File: rtl/restore_div_pkg.sv
// Shared types and width helpers for the restoring divider.
package restore_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Partial remainder needs one guard bit above 2*WIDTH so the borrow lands in the MSB.
  function automatic int rem_width(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int step_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/restore_cell.sv
// One restoring compare-subtract step: trial-subtract the shifted divisor and keep it if no borrow.
module restore_cell
  import restore_div_pkg::*;
#(
  parameter int  WIDTH  = 4,
  localparam int REM_W  = rem_width(WIDTH),
  localparam int STEP_W = step_width(WIDTH)
) (
  input  logic [REM_W-1:0]  rem_i,
  input  logic [WIDTH-1:0]  divisor_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [REM_W-1:0]  rem_o,
  output logic              q_bit_o
);

  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] sub;

  assign shifted = REM_W'(divisor_i) << step_i;
  assign sub     = rem_i - shifted;
  assign q_bit_o = ~sub[REM_W-1];
  assign rem_o   = q_bit_o ? sub : rem_i;

endmodule

// File: rtl/restore_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define RESTORE_DIV_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE with div_by_zero set.
module restore_div_seq
  import restore_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int REM_W  = rem_width(WIDTH);
  localparam int STEP_W = step_width(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  divisor_q, divisor_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [REM_W-1:0]  cell_rem;
  logic              cell_q_bit;

  restore_cell #(
    .WIDTH (WIDTH)
  ) u_cell (
    .rem_i     (rem_q),
    .divisor_i (divisor_q),
    .step_i    (step_q),
    .rem_o     (cell_rem),
    .q_bit_o   (cell_q_bit)
  );

`ifdef RESTORE_DIV_ZERO_CHECK_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    step_d    = step_q;
`ifdef RESTORE_DIV_ZERO_CHECK_EN
    dbz_d     = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          divisor_d = divisor;
          rem_d     = REM_W'(dividend);
          quot_d    = '0;
          step_d    = STEP_W'(WIDTH - 1);
          state_d   = CALC;
`ifdef RESTORE_DIV_ZERO_CHECK_EN
          dbz_d     = (divisor == '0);
          if (divisor == '0) begin
            quot_d  = '1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        rem_d          = cell_rem;
        quot_d[step_q] = cell_q_bit;
        if (step_q == '0) begin
          state_d = DONE;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      DONE: begin
        if (dout_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      step_q    <= step_d;
    end
  end

`ifdef RESTORE_DIV_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign din_ready  = (state_q == IDLE);
  assign dout_valid = (state_q == DONE);
  assign quotient   = quot_q;
  assign remainder  = rem_q[WIDTH-1:0];

endmodule
